// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : traffic_pkg
// Brief   : Light-state encodings and default timing constants for the
//           traffic-light controller and its timer/sensor partner.
// Rev     : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Lamp order {main R,Y,G, side R,Y,G}; exactly one lamp lit per road.
  typedef enum logic [5:0] {
    MRG = 6'b001_100,
    MRY = 6'b010_100,
    SRG = 6'b100_001,
    SRY = 6'b100_010
  } light_t;

  localparam int unsigned CLK_PER_TICK_DEF = 10;
  localparam int unsigned T_SHORT_DEF      = 4;
  localparam int unsigned T_LONG_DEF       = 14;
  localparam int unsigned CW_DEF           = 8;
  localparam int unsigned DEB_DEF          = 3;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_debounce.sv
`default_nettype none
// ============================================================================
// Module  : car_debounce
// Brief   : Two-flop synchroniser plus DEB-sample stability filter for the
//           side-road car sensor.
// Rev     : 1.0  initial release
// ============================================================================
module car_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB = DEB_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic car_raw,
  output logic car_filt,
  output logic car_rise
);

  localparam int unsigned c_DW = cnt_width(DEB);

  logic            r_meta;
  logic            r_sync;
  logic            r_filt;
  logic [c_DW-1:0] r_cnt;
  logic            w_differ;
  logic            w_done;

  assign w_differ = r_sync ^ r_filt;
  // Filtered level flips on the edge where the DEB-th disagreeing sample is seen.
  assign w_done   = w_differ && (r_cnt == c_DW'(DEB - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= car_raw;
      r_sync <= r_meta;
      if (w_done) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else if (w_differ) begin
        r_cnt  <= r_cnt + c_DW'(1);
      end else begin
        r_cnt  <= '0;
      end
    end
  end

  assign car_filt = r_filt;
  // Strobe valid in the cycle before car_filt goes high, so the request latch
  // can arbitrate against SG on the very same edge.
  assign car_rise = w_done & r_sync;

endmodule
`default_nettype wire

// File: rtl/traffic_timer_sensor.sv
`default_nettype none
// ============================================================================
// Module  : traffic_timer_sensor
// Brief   : Interval timer with tick prescaler, TS/TL gating and side-road
//           car request latch feeding the traffic-light fsm.
// Rev     : 1.0  initial release
// ============================================================================
module traffic_timer_sensor
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = CLK_PER_TICK_DEF,
  parameter int unsigned T_SHORT      = T_SHORT_DEF,
  parameter int unsigned T_LONG       = T_LONG_DEF,
  parameter int unsigned CW           = CW_DEF,
  parameter int unsigned DEB          = DEB_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ST,
  input  logic          SG,
  input  logic          car_raw,
  output logic          TS,
  output logic          TL,
  output logic          C,
  output logic [CW-1:0] tick_cnt
);

  localparam int unsigned c_PW = cnt_width(CLK_PER_TICK);

  logic [c_PW-1:0] r_presc;
  logic [CW-1:0]   r_tick_cnt;
  logic            r_car_req;
  logic            w_tick;
  logic            w_at_long;
  logic            w_car_filt;
  logic            w_car_rise;

  assign w_tick    = (r_presc == c_PW'(CLK_PER_TICK - 1));
  assign w_at_long = (r_tick_cnt >= CW'(T_LONG));

  // ST restarts both counters and beats a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if (ST) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
      if (w_tick && !w_at_long) begin
        r_tick_cnt <= r_tick_cnt + CW'(1);
      end
    end
  end

  // Gating with ~ST hides the stale count in the restart cycle.
  assign TS       = (r_tick_cnt >= CW'(T_SHORT)) & ~ST;
  assign TL       = w_at_long & ~ST;
  assign tick_cnt = r_tick_cnt;

  car_debounce #(
    .DEB      (DEB)
  ) u_car_debounce (
    .clk      (clk),
    .rst      (rst),
    .car_raw  (car_raw),
    .car_filt (w_car_filt),
    .car_rise (w_car_rise)
  );

  // SG clear wins, so during side green C follows the live filtered level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_car_req <= 1'b0;
    end else if (SG) begin
      r_car_req <= 1'b0;
    end else if (w_car_rise) begin
      r_car_req <= 1'b1;
    end
  end

  assign C = w_car_filt | r_car_req;

endmodule
`default_nettype wire

// File: tb/tb_traffic_timer_sensor.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_timer_sensor
// Brief   : Directed plus randomised self-checking bench for
//           traffic_timer_sensor against a behavioural reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_traffic_timer_sensor;
  import traffic_pkg::*;

  localparam int CPT = 10;
  localparam int TSH = 4;
  localparam int TLG = 14;
  localparam int CW  = 8;
  localparam int DEB = 3;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          ST      = 1'b0;
  logic          SG      = 1'b0;
  logic          car_raw = 1'b0;
  logic          TS;
  logic          TL;
  logic          C;
  logic [CW-1:0] tick_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_timer_sensor #(
    .CLK_PER_TICK (CPT),
    .T_SHORT      (TSH),
    .T_LONG       (TLG),
    .CW           (CW),
    .DEB          (DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ST       (ST),
    .SG       (SG),
    .car_raw  (car_raw),
    .TS       (TS),
    .TL       (TL),
    .C        (C),
    .tick_cnt (tick_cnt)
  );

  // Reference model: timer as "edges since last restart" divided by the tick
  // period; car path as a two-deep sample delay plus a sliding sample window.
  int m_n;
  bit m_raw1, m_sync, m_filt, m_req, m_rose, m_all;
  bit hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n    = 0;
      m_raw1 = 0;
      m_sync = 0;
      m_filt = 0;
      m_req  = 0;
      hist.delete();
    end else begin
      if (ST) m_n = 0;
      else if (m_n < 1000000) m_n++;
      m_rose = 0;
      hist.push_back(m_sync);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        m_all = 1;
        for (int i = 0; i < DEB; i++) if (hist[i] == m_filt) m_all = 0;
        if (m_all) begin
          m_filt = !m_filt;
          m_rose = m_filt;
          hist.delete();
        end
      end
      m_sync = m_raw1;
      m_raw1 = car_raw;
      if (SG) m_req = 0;
      else if (m_rose) m_req = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int et;
    et = (m_n / CPT >= TLG) ? TLG : m_n / CPT;
    chk({tag, "_tick"}, 32'(tick_cnt), 32'(et));
    chk({tag, "_ts"},   32'(TS), 32'((et >= TSH) && !ST));
    chk({tag, "_tl"},   32'(TL), 32'((et >= TLG) && !ST));
    chk({tag, "_c"},    32'(C),  32'(m_filt | m_req));
  endtask

  task automatic cyc(input int n, input string tag = "run");
    repeat (n) begin
      @(posedge clk);
      #2;
      chk_all(tag);
    end
  endtask

  int edges;
  int run_left;

  initial begin
    // Reset, then count to tick_cnt=7 with a car present, then async reset.
    cyc(2, "in_rst");
    rst = 1'b1;
    car_raw = 1'b1;
    cyc(70, "t1_run");
    chk("t1_pre_tick", 32'(tick_cnt), 32'd7);
    chk("t1_pre_c", 32'(C), 32'd1);
    rst = 1'b0;
    car_raw = 1'b0;
    #1;
    chk("t1_async_ts", 32'(TS), 32'd0);
    chk("t1_async_tl", 32'(TL), 32'd0);
    chk("t1_async_c", 32'(C), 32'd0);
    chk("t1_async_tick", 32'(tick_cnt), 32'd0);
    cyc(2, "t1_hold");
    rst = 1'b1;
    edges = 0;
    while (!TS && edges < 200) begin cyc(1, "t1_rel"); edges++; end
    chk("t1_ts_after_rel", 32'(edges), 32'd40);

    // 1-cycle ST pulse: TS after 40 edges, TL after 140, then saturation.
    ST = 1'b1;
    cyc(1, "t2_st");
    ST = 1'b0;
    edges = 0;
    while (!TS && edges < 300) begin cyc(1, "t2_ts"); edges++; end
    chk("t2_ts_edges", 32'(edges), 32'd40);
    while (!TL && edges < 300) begin cyc(1, "t2_tl"); edges++; end
    chk("t2_tl_edges", 32'(edges), 32'd140);
    cyc(300, "t2_sat");
    chk("t2_sat_tick", 32'(tick_cnt), 32'd14);

    // Restart with TL=1 gates outputs immediately; ST beats coincident tick.
    ST = 1'b1;
    #1;
    chk("t3_gate_ts", 32'(TS), 32'd0);
    chk("t3_gate_tl", 32'(TL), 32'd0);
    cyc(1, "t3_st");
    chk("t3_tick0", 32'(tick_cnt), 32'd0);
    ST = 1'b0;
    cyc(9, "t3_pre");
    ST = 1'b1;
    cyc(1, "t3_coinc");
    chk("t3_st_over_tick", 32'(tick_cnt), 32'd0);
    ST = 1'b0;
    cyc(10, "t3_post");
    chk("t3_first_tick", 32'(tick_cnt), 32'd1);

    // 2-cycle glitch is rejected; 5-cycle pulse latches until SG.
    car_raw = 1'b1;
    cyc(2, "t4_gl");
    car_raw = 1'b0;
    cyc(8, "t4_gl");
    chk("t4_glitch_c", 32'(C), 32'd0);
    car_raw = 1'b1;
    cyc(4, "t4_p");
    chk("t4_edge4_c", 32'(C), 32'd0);
    cyc(1, "t4_p");
    chk("t4_edge5_c", 32'(C), 32'd1);
    car_raw = 1'b0;
    cyc(12, "t4_hold");
    chk("t4_latched_c", 32'(C), 32'd1);
    SG = 1'b1;
    cyc(1, "t4_sg");
    chk("t4_sg_clear_c", 32'(C), 32'd0);
    SG = 1'b0;

    // SG coincident with the filtered rise: request never latches.
    car_raw = 1'b1;
    cyc(4, "t5_rise");
    SG = 1'b1;
    cyc(1, "t5_rise");
    chk("t5_c_filt", 32'(C), 32'd1);
    SG = 1'b0;
    cyc(3, "t5_on");
    car_raw = 1'b0;
    cyc(4, "t5_fall");
    chk("t5_fall_e4", 32'(C), 32'd1);
    cyc(1, "t5_fall");
    chk("t5_fall_e5", 32'(C), 32'd0);

    // Randomised traffic with one mid-cycle asynchronous reset.
    run_left = 0;
    for (int k = 0; k < 800; k++) begin
      if (run_left == 0) begin
        car_raw  = 1'($urandom_range(1, 0));
        run_left = $urandom_range(8, 1);
      end
      run_left--;
      ST = ($urandom_range(59, 0) == 0);
      SG = ($urandom_range(19, 0) == 0);
      if (k == 400) begin
        rst = 1'b0;
        #1;
        chk_all("rnd_async");
        rst = 1'b1;
      end
      cyc(1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
